pipe_elastic_reg: RTL and testbench
===================================

// Module: pipe_elastic_reg
// PURPOSE
//  Parametrised successor of the enable/sync-clear pipeline register: a
//  DEPTH-entry elastic pipeline stage with valid/ready handshake on both sides
//  and a synchronous flush that empties the stage. Sits between RISC-V pipeline
//  stages (e.g. fetch->decode, issue->execute) so a back-pressured stage stalls
//  upstream without losing data, and a branch/exception flush kills in-flight state.
// PARAMETERS
//  WIDTH    32  payload width in bits (>=1)
//  DEPTH    2   number of buffer entries (>=1, need not be a power of 2)
//  CLR_VAL  0   WIDTH-bit value driven on o_data when the stage holds no valid entry
// PORTS
//  i_clk    in   1                    clock, all state updates on posedge
//  i_rst    in   1                    synchronous reset, active-high
//  i_flush  in   1                    synchronous flush: empty the stage this edge
//  i_valid  in   1                    upstream has payload on i_data
//  o_ready  out  1                    stage can accept a payload this cycle
//  i_data   in   WIDTH                upstream payload
//  o_valid  out  1                    head entry valid on o_data
//  i_ready  in   1                    downstream accepts head entry this cycle
//  o_data   out  WIDTH                head entry payload, CLR_VAL when !o_valid
//  o_count  out  $clog2(DEPTH+1)      number of valid entries held (0..DEPTH)
// BEHAVIOUR
//  - Single clock i_clk; i_rst synchronous, active-high; no async reset.
//  - Storage: DEPTH x WIDTH circular buffer, write pointer wp, read pointer rp,
//    occupancy cnt. Pointers wrap DEPTH-1 -> 0 explicitly (no power-of-2 masking).
//  - Reset (i_rst=1 at edge): wp=rp=0, cnt=0, all entries = CLR_VAL.
//    Post-reset outputs: o_valid=0, o_ready=1, o_count=0, o_data=CLR_VAL.
//    i_valid/i_ready ignored during the reset cycle.
//  - Flush (i_flush=1, i_rst=0): identical state effect to reset; any push or pop
//    offered in the same cycle is discarded (push not stored, pop not counted).
//    Priority: i_rst > i_flush > push/pop.
//  - Occupancy states: EMPTY (cnt=0), PARTIAL (0<cnt<DEPTH), FULL (cnt=DEPTH).
//    DEPTH=1 has no PARTIAL state.
//  - o_ready = (cnt != DEPTH); o_valid = (cnt != 0). Both depend only on registered
//    state: no combinational path from i_ready to o_ready or i_valid to o_valid.
//  - push = i_valid & o_ready; pop = o_valid & i_ready.
//    push: mem[wp] <= i_data, wp advances. pop: entry at rp <= CLR_VAL, rp advances.
//    cnt <= cnt + push - pop (push&pop -> cnt unchanged, both pointers advance).
//  - Transitions: EMPTY--push-->PARTIAL/FULL(DEPTH=1); PARTIAL--push&!pop-->cnt+1;
//    PARTIAL--pop&!push-->cnt-1; FULL--pop-->cnt-1 (push blocked, o_ready=0);
//    EMPTY never pops (o_valid=0). Any state --flush/reset--> EMPTY.
//  - Latency: payload pushed at edge N is visible on o_data with o_valid=1 after
//    edge N when stage was EMPTY (1-cycle latency); otherwise in order behind older entries.
//  - Ordering: strict FIFO; no entry dropped or duplicated except by flush/reset.
//  - Stall: i_ready=0 holds o_data/o_valid stable until accepted.
//  - o_data = mem[rp] when o_valid else CLR_VAL; o_count = cnt.
//  - Handshake rule for upstream: once i_valid=1 with o_ready=0, upstream may hold
//    or change i_data; only the value present on the accepting edge is stored.
// TESTING
//  1 Reset: assert i_rst 1 cycle with i_valid=1 -> o_valid=0, o_ready=1, o_count=0,
//    o_data=CLR_VAL; nothing stored.
//  2 Pass-through (DEPTH=2): i_ready=1, push 0x11,0x22,0x33 back-to-back -> o_data
//    0x11,0x22,0x33 on consecutive cycles, each 1 cycle after push, o_count stays 1.
//  3 Fill/stall: i_ready=0, push 0xA,0xB -> o_count=2, o_ready=0, third push 0xC
//    refused; raise i_ready -> 0xA then 0xB out, o_ready=1 after first pop, then 0xC accepted.
//  4 Simultaneous push+pop at FULL vs PARTIAL: PARTIAL cnt=1 push+pop -> cnt=1,
//    order kept; FULL with i_valid=1,i_ready=1 -> only pop, cnt 2->1.
//  5 Flush: cnt=2, assert i_flush with i_valid=1 (0x55) and i_ready=1 -> next cycle
//    o_valid=0, o_count=0, o_data=CLR_VAL, 0x55 never appears.
//  6 Wrap (DEPTH=3): 10 randomised push/pop cycles across pointer wrap -> output
//    sequence equals input sequence, o_count matches scoreboard every cycle.

Source files
------------

// File: rtl/pipe_elastic_reg.sv
// pipe_elastic_reg
//   DEPTH-entry elastic pipeline stage with a valid/ready handshake on both
//   sides and a synchronous flush. It sits between pipeline stages so that a
//   stalled consumer back-pressures the producer without losing data, and a
//   branch or exception flush discards everything in flight.
//
// Handshake: a transfer happens on a rising edge where valid and ready are both
//   high on the same side. The stage's o_ready and o_valid come only from
//   registered occupancy, so neither depends combinationally on i_valid or i_ready.
//   Upstream may hold or change i_data while o_ready=0. Only the value present on
//   the accepting edge is stored.
//
// Parameters
//   WIDTH    payload width in bits (>=1)
//   DEPTH    number of buffer entries (>=1, any value, not only powers of 2)
//   CLR_VAL  value driven on o_data while the stage is empty
//
// Ports
//   i_clk    clock; all state changes on the rising edge
//   i_rst    synchronous reset, active-high
//   i_flush  synchronous flush; empties the stage and drops any push or pop
//            offered in the same cycle
//   i_valid  upstream offers i_data
//   o_ready  stage can accept a payload (not full)
//   i_data   upstream payload
//   o_valid  head entry is valid on o_data
//   i_ready  downstream takes the head entry
//   o_data   head entry payload, CLR_VAL while empty
//   o_count  number of valid entries (0..DEPTH)
//   o_state  occupancy state: EMPTY / PARTIAL / FULL (debug)
module pipe_elastic_reg #(
  parameter int                WIDTH   = 32,
  parameter int                DEPTH   = 2,
  parameter logic [WIDTH-1:0]  CLR_VAL = '0
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_flush,
  input  logic                       i_valid,
  output logic                       o_ready,
  input  logic [WIDTH-1:0]           i_data,
  output logic                       o_valid,
  input  logic                       i_ready,
  output logic [WIDTH-1:0]           o_data,
  output logic [$clog2(DEPTH+1)-1:0] o_count,
  output logic [1:0]                 o_state
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

  // Occupancy states, decoded from cnt.
  localparam logic [1:0] ST_EMPTY   = 2'd0;
  localparam logic [1:0] ST_PARTIAL = 2'd1;
  localparam logic [1:0] ST_FULL    = 2'd2;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wp;
  logic [PTR_W-1:0] rp;
  logic [CNT_W-1:0] cnt;

  logic push;
  logic pop;

  assign o_ready = (cnt != FULL_CNT);
  assign o_valid = (cnt != '0);
  assign o_count = cnt;
  assign o_data  = o_valid ? mem[rp] : CLR_VAL;

  always_comb begin
    push = i_valid && o_ready;
    pop  = o_valid && i_ready;
  end

  always_comb begin
    o_state = ST_PARTIAL;
    if (cnt == '0) begin
      o_state = ST_EMPTY;
    end else if (cnt == FULL_CNT) begin
      o_state = ST_FULL;
    end
  end

  // When a push and a pop happen together, wp and rp always differ.
  // A push needs cnt<DEPTH and a pop needs cnt>0, and wp==rp only at
  // cnt==0 or cnt==DEPTH. So the two writes below never hit the same entry.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= CLR_VAL;
      end
    end else begin
      if (pop) begin
        mem[rp] <= CLR_VAL;
        rp      <= (rp == PTR_LAST) ? '0 : rp + 1'b1;
      end
      if (push) begin
        mem[wp] <= i_data;
        wp      <= (wp == PTR_LAST) ? '0 : wp + 1'b1;
      end
      if (push && !pop) begin
        cnt <= cnt + 1'b1;
      end else if (pop && !push) begin
        cnt <= cnt - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pipe_elastic_reg.sv
// tb_pipe_elastic_reg
//   Drives one stimulus stream into two instances: a 2-entry stage and a 3-entry stage.
//   Each instance has its own reference model, made of an occupancy counter and
//   an expected-data queue. Expected data is pushed when the model accepts a
//   payload. It is popped and compared when the model says the DUT hands one out.
module tb_pipe_elastic_reg;

  localparam int          W   = 32;
  localparam logic [W-1:0] CLR = 32'hDEAD_BEEF;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         flush;
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         out_ready;

  logic         rdy2, vld2;
  logic [W-1:0] dat2;
  logic [1:0]   cnt2;
  logic [1:0]   st2;

  logic         rdy3, vld3;
  logic [W-1:0] dat3;
  logic [1:0]   cnt3;
  logic [1:0]   st3;

  pipe_elastic_reg #(.WIDTH(W), .DEPTH(2), .CLR_VAL(CLR)) dut2 (
    .i_clk(clk), .i_rst(rst), .i_flush(flush),
    .i_valid(in_valid), .o_ready(rdy2), .i_data(in_data),
    .o_valid(vld2), .i_ready(out_ready), .o_data(dat2),
    .o_count(cnt2), .o_state(st2)
  );

  pipe_elastic_reg #(.WIDTH(W), .DEPTH(3), .CLR_VAL(CLR)) dut3 (
    .i_clk(clk), .i_rst(rst), .i_flush(flush),
    .i_valid(in_valid), .o_ready(rdy3), .i_data(in_data),
    .o_valid(vld3), .i_ready(out_ready), .o_data(dat3),
    .o_count(cnt3), .o_state(st3)
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q2[$];
  logic [W-1:0] exp_q3[$];
  int           m_cnt2;
  int           m_cnt3;
  bit           model_known;
  int           checks;
  int           failures;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] state_of(input int c, input int depth);
    if (c == 0)     return 2'd0;
    if (c == depth) return 2'd2;
    return 2'd1;
  endfunction

  // ---------------- driver ----------------
  // One clock cycle: drive the inputs, check the head/ready/valid from the
  // model, take the edge, update the model, then check count and state.
  task automatic cycle(input bit r, input bit f, input bit v, input logic [W-1:0] d,
                       input bit rd);
    bit p2, q2, p3, q3;
    rst       = r;
    flush     = f;
    in_valid  = v;
    in_data   = d;
    out_ready = rd;
    #1;
    p2 = 0; q2 = 0; p3 = 0; q3 = 0;
    if (model_known) begin
      chk("ready2", W'(rdy2), W'(m_cnt2 != 2));
      chk("valid2", W'(vld2), W'(m_cnt2 != 0));
      chk("data2",  dat2, (m_cnt2 != 0) ? exp_q2[0] : CLR);
      chk("ready3", W'(rdy3), W'(m_cnt3 != 3));
      chk("valid3", W'(vld3), W'(m_cnt3 != 0));
      chk("data3",  dat3, (m_cnt3 != 0) ? exp_q3[0] : CLR);
      if (!r && !f) begin
        p2 = v && (m_cnt2 != 2);
        q2 = rd && (m_cnt2 != 0);
        p3 = v && (m_cnt3 != 3);
        q3 = rd && (m_cnt3 != 0);
      end
    end
    @(posedge clk);
    #1;
    if (r || f) begin
      exp_q2.delete();
      exp_q3.delete();
      m_cnt2 = 0;
      m_cnt3 = 0;
      model_known = 1'b1;
    end else begin
      if (q2) void'(exp_q2.pop_front());
      if (p2) exp_q2.push_back(d);
      m_cnt2 = m_cnt2 + int'(p2) - int'(q2);
      if (q3) void'(exp_q3.pop_front());
      if (p3) exp_q3.push_back(d);
      m_cnt3 = m_cnt3 + int'(p3) - int'(q3);
    end
    chk("count2", W'(cnt2), W'(m_cnt2));
    chk("state2", W'(st2), W'(state_of(m_cnt2, 2)));
    chk("count3", W'(cnt3), W'(m_cnt3));
    chk("state3", W'(st3), W'(state_of(m_cnt3, 3)));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    checks      = 0;
    failures    = 0;
    m_cnt2      = 0;
    m_cnt3      = 0;
    model_known = 1'b0;
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

    // Reset with i_valid high: nothing may be stored
    cycle(1, 0, 1, 32'h0000_00AA, 1);
    chk("rst_valid", W'(vld2), '0);
    chk("rst_ready", W'(rdy2), 32'd1);
    chk("rst_count", W'(cnt2), '0);
    chk("rst_data",  dat2, CLR);

    // Pass-through: back-to-back pushes with the consumer always ready
    cycle(0, 0, 1, 32'h11, 1);
    chk("pt_head0", dat2, 32'h11);
    cycle(0, 0, 1, 32'h22, 1);
    chk("pt_head1", dat2, 32'h22);
    cycle(0, 0, 1, 32'h33, 1);
    chk("pt_head2", dat2, 32'h33);
    chk("pt_count", W'(cnt2), 32'd1);
    cycle(0, 0, 0, 32'h0, 1);

    // Fill and stall, then drain while 0xC is still offered
    cycle(0, 0, 1, 32'hA, 0);
    cycle(0, 0, 1, 32'hB, 0);
    chk("fill_count", W'(cnt2), 32'd2);
    chk("fill_ready", W'(rdy2), '0);
    cycle(0, 0, 1, 32'hC, 0);     // refused by the 2-entry stage
    chk("fill_head", dat2, 32'hA);
    cycle(0, 0, 1, 32'hC, 1);     // pop 0xA, push blocked
    chk("drain_ready", W'(rdy2), 32'd1);
    cycle(0, 0, 1, 32'hC, 1);     // pop 0xB, 0xC accepted
    cycle(0, 0, 0, 32'h0, 1);
    cycle(0, 0, 0, 32'h0, 1);
    cycle(0, 0, 0, 32'h0, 1);

    // Simultaneous push and pop: first at PARTIAL, then at FULL
    cycle(0, 0, 1, 32'h41, 0);
    cycle(0, 0, 1, 32'h42, 1);    // partial: count stays 1
    chk("pp_partial_cnt", W'(cnt2), 32'd1);
    cycle(0, 0, 1, 32'h43, 0);    // 2-entry stage is now full
    cycle(0, 0, 1, 32'h44, 1);    // full: only the pop happens
    chk("pp_full_cnt", W'(cnt2), 32'd1);
    cycle(0, 0, 0, 32'h0, 1);
    cycle(0, 0, 0, 32'h0, 1);
    cycle(0, 0, 0, 32'h0, 1);

    // Flush while full, with a push and a pop offered in the same cycle
    cycle(0, 0, 1, 32'h51, 0);
    cycle(0, 0, 1, 32'h52, 0);
    cycle(0, 1, 1, 32'h55, 1);
    chk("flush_valid", W'(vld2), '0);
    chk("flush_count", W'(cnt2), '0);
    chk("flush_data",  dat2, CLR);
    cycle(0, 0, 0, 32'h0, 1);
    cycle(0, 0, 0, 32'h0, 1);

    // Randomised traffic across pointer wrap; the model checks every cycle
    for (int i = 0; i < 40; i++) begin
      cycle(0, 0, 1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)));
    end
    for (int i = 0; i < 5; i++) begin
      cycle(0, 0, 0, 32'h0, 1);
    end
    chk("final_count3", W'(cnt3), '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
